iq_age_select: RTL

Parametrised multi-port issue-queue select block for the out-of-order backend. Holds DEPTH entries (valid flag, opcode, compact relative age). Each cycle, every issue port grants the oldest ready entry whose opcode matches that port. Allocation, issue and flush update the entry state and ages sequentially. It generalises the single-port combinational arbiter to ISSUE_WIDTH ports, adds internal age bookkeeping and per-port functional-unit backpressure, and registers the grant outputs.

---
 rtl/iq_age_select.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/iq_age_select.sv
// Multi-port, age-ordered select for an issue queue.
// Each issue port grants the oldest entry that is valid, operand-ready and
// opcode-matched, provided its functional unit can accept.
// Ports are served in priority order, with port 0 highest.
// The block also keeps per-entry age bookkeeping across alloc, issue and flush.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush           clear every entry (overrides alloc/issue)
//   alloc_*         write one entry (valid/addr/op)
//   req             per-entry operands-ready
//   port_op         opcode class served by each port (slice p)
//   port_ready      per-port functional-unit accept
//   grant[_addr]    registered per-port issue strobe and entry index
//   entry_valid     occupied entries
//   count/full/empty occupancy
//   alloc_err       registered pulse when an alloc hits an occupied entry
module iq_age_select #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned OPCODE_WIDTH = 7,
    parameter int unsigned ISSUE_WIDTH  = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                alloc_valid,
    input  logic [ADDR_WIDTH-1:0]               alloc_addr,
    input  logic [OPCODE_WIDTH-1:0]             alloc_op,
    input  logic [DEPTH-1:0]                    req,
    input  logic [ISSUE_WIDTH*OPCODE_WIDTH-1:0] port_op,
    input  logic [ISSUE_WIDTH-1:0]              port_ready,
    output logic [ISSUE_WIDTH-1:0]              grant,
    output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]   grant_addr,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [ADDR_WIDTH:0]                 count,
    output logic                                full,
    output logic                                empty,
    output logic                                alloc_err
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [DEPTH-1:0]        valid_q;
    logic [OPCODE_WIDTH-1:0] op_q  [DEPTH];
    logic [ADDR_WIDTH-1:0]   age_q [DEPTH];
    logic [CNT_WIDTH-1:0]    count_q;

    logic [ISSUE_WIDTH-1:0]  pick_c;
    logic [ADDR_WIDTH-1:0]   pick_idx_c [ISSUE_WIDTH];
    logic [ADDR_WIDTH-1:0]   best_age_c;
    logic [DEPTH-1:0]        issued_c;
    logic [CNT_WIDTH-1:0]    n_issued_c;
    logic [CNT_WIDTH-1:0]    count_kept_c;
    logic [CNT_WIDTH-1:0]    count_next_c;
    logic [ADDR_WIDTH-1:0]   age_next_c [DEPTH];
    logic                    alloc_ok_c;

    // Priority chain of oldest-first pickers; issued_c masks earlier ports' picks.
    always_comb begin
        issued_c   = '0;
        pick_c     = '0;
        best_age_c = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            pick_idx_c[p] = '0;
            best_age_c    = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && req[i] && !issued_c[i] && port_ready[p] &&
                    (op_q[i] == port_op[p*OPCODE_WIDTH +: OPCODE_WIDTH]) &&
                    (!pick_c[p] || (age_q[i] < best_age_c))) begin
                    pick_c[p]     = 1'b1;
                    pick_idx_c[p] = ADDR_WIDTH'(i);
                    best_age_c    = age_q[i];
                end
            end
            if (pick_c[p]) begin
                issued_c[pick_idx_c[p]] = 1'b1;
            end
        end
    end

    // Age compaction: each survivor drops by the number of older entries issued.
    always_comb begin
        n_issued_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issued_c[i]) begin
                n_issued_c = n_issued_c + CNT_WIDTH'(1);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            age_next_c[i] = '0;
            if (valid_q[i] && !issued_c[i]) begin
                age_next_c[i] = age_q[i];
                for (int j = 0; j < DEPTH; j++) begin
                    if (issued_c[j] && (age_q[j] < age_q[i])) begin
                        age_next_c[i] = age_next_c[i] - ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

    // An entry being issued this cycle is still valid here, so allocating into it is rejected.
    assign alloc_ok_c   = alloc_valid && !valid_q[alloc_addr];
    assign count_kept_c = count_q - n_issued_c;
    assign count_next_c = count_kept_c + CNT_WIDTH'(alloc_ok_c);

    // Entry state, occupancy and registered grant/error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            count_q    <= '0;
            grant      <= '0;
            grant_addr <= '0;
            alloc_err  <= 1'b0;
            full       <= 1'b0;
            empty      <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                age_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q    <= '0;
            count_q    <= '0;
            grant      <= '0;
            grant_addr <= '0;
            alloc_err  <= 1'b0;
            full       <= 1'b0;
            empty      <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_next_c[i];
                if (issued_c[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            // New entry becomes the youngest after this cycle's compaction.
            if (alloc_ok_c) begin
                valid_q[alloc_addr] <= 1'b1;
                op_q[alloc_addr]    <= alloc_op;
                age_q[alloc_addr]   <= ADDR_WIDTH'(count_kept_c);
            end
            count_q   <= count_next_c;
            full      <= (count_next_c == CNT_WIDTH'(DEPTH));
            empty     <= (count_next_c == '0);
            alloc_err <= alloc_valid && !alloc_ok_c;
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                grant[p]                                <= pick_c[p];
                grant_addr[p*ADDR_WIDTH +: ADDR_WIDTH]  <= pick_c[p] ? pick_idx_c[p] : '0;
            end
        end
    end

    assign entry_valid = valid_q;
    assign count       = count_q;

endmodule
